mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameter COUNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  RAM completion handshake, sampled at the rising edge.
REQ-007 mem_read, mem_write, i_or_d, ir_write  output  1 each  RAM read/write strobes, address select (0=PC, 1=ALUOut), IR load enable.
REQ-008 pc_en  output  1  PC load enable, with unconditional and branch-qualified cases merged.
REQ-009 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write enable, destination select (0=rt, 1=rd), write-data select (1=MDR).
REQ-010 alu_src_a  output  1  ALU A select (0=PC, 1=A reg).
REQ-011 alu_src_b  output  2  ALU B select (00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2).
REQ-012 alu_op  output  2  ALU operation (00=add, 01=sub, 10=funct decode).
REQ-013 pc_source  output  2  PC source (00=ALU result, 01=ALUOut, 10=jump address).
REQ-014 retire  output  1  one-cycle pulse when an instruction completes.
REQ-015 instr_count  output  COUNT_W  retired-instruction count.
REQ-016 illegal  output  1  sticky flag for an unsupported opcode.
REQ-017 state  output  4  current FSM state, for debug.

Function
REQ-018 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
REQ-019 States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=15.
REQ-020 Outputs are a Moore decode of state; pc_en, ir_write and retire are the only outputs that may also depend on mem_ready or zero.
REQ-021 Every output not listed for a state is 0 in that state.
REQ-022 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_en=mem_ready. Go to DECODE when mem_ready=1, otherwise hold.
REQ-023 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode: lw/sw->MEM_ADDR, R->R_EXEC, beq/bne->BRANCH, j->JUMP, addi->ADDI_EXEC, any other->TRAP.
REQ-024 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw->MEM_READ, sw->MEM_WRITE.
REQ-025 MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
REQ-026 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
REQ-027 MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH.
REQ-028 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_en=zero for beq and pc_en=~zero for bne. Then FETCH.
REQ-030 JUMP: pc_source=10, pc_en=1, then FETCH.
REQ-031 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
REQ-032 retire=1 in MEM_WB, R_WB, BRANCH, JUMP and ADDI_WB. In MEM_WRITE, retire=1 only when mem_ready=1.
REQ-033 instr_count increments by 1 on each edge where retire=1 and wraps modulo 2^COUNT_W.
REQ-034 TRAP: all strobes are 0 and illegal=1. TRAP is held until reset, and retire is never asserted from TRAP.
REQ-035 With zero-wait memory (mem_ready=1), cycles per instruction are: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3. Each cycle mem_ready stays 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
REQ-036 A mem_ready asserted outside FETCH, MEM_READ and MEM_WRITE is ignored.

Reset
REQ-037 Asserting reset asynchronously forces state=FETCH, instr_count=0 and illegal=0, including when it arrives mid-instruction or during a memory wait.
REQ-038 While reset=1, every control output is forced to 0, including the FETCH mem_read.
REQ-039 The first FETCH strobes appear in the first cycle after reset is deasserted.

Structure
REQ-040 The state encodings, opcode constants, and alu_op/alu_src_b/pc_source encodings live in the shared package mips_ctrl_pkg.
REQ-041 The combinational opcode classifier lives in the sub-module mips_opcode_decode, which outputs a one-hot class of R/lw/sw/branch/j/addi/illegal plus an is_bne bit.

Verification
REQ-042 Reset with mem_ready=1, then feed opcode 100011 -> states 0,1,2,3,4,0, one retire pulse, instr_count=1.
REQ-043 sw (101011) with mem_ready held 0 for 3 cycles in MEM_WRITE -> mem_write=1 for 4 cycles, then retire, 7 cycles total.
REQ-044 beq with zero=1 -> pc_en=1 and pc_source=01 in BRANCH. bne with zero=1 -> pc_en=0.
REQ-045 opcode 111111 -> TRAP, illegal=1, no strobes for 10 cycles, then reset clears illegal and returns the FSM to FETCH.
REQ-046 Assert reset mid-MEM_READ -> outputs go to 0 within the same cycle, instr_count=0, and state=FETCH.
REQ-047 With COUNT_W=4, retire 17 R-type instructions -> instr_count=1 after wrap-around.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcodes, datapath mux selects and opcode classes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_TRAP      = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   // One-hot instruction class produced by the opcode decoder
   typedef struct packed {
      logic r;
      logic lw;
      logic sw;
      logic br;
      logic j;
      logic addi;
      logic ill;
   } op_class_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode classifier: one-hot class plus a bne flag
// so the FSM can pick the branch polarity.
module mips_opcode_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_t  cls,
   output logic       is_bne
);

   always_comb begin
      cls    = '0;
      is_bne = 1'b0;
      unique case (opcode)
         OP_RTYPE: cls.r    = 1'b1;
         OP_LW:    cls.lw   = 1'b1;
         OP_SW:    cls.sw   = 1'b1;
         OP_BEQ:   cls.br   = 1'b1;
         OP_BNE: begin
            cls.br = 1'b1;
            is_bne = 1'b1;
         end
         OP_J:     cls.j    = 1'b1;
         OP_ADDI:  cls.addi = 1'b1;
         default:  cls.ill  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake, retire counter
// and a sticky illegal-opcode trap.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               ir_write,
   output logic               pc_en,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               retire,
   output logic [COUNT_W-1:0] instr_count,
   output logic               illegal,
   output logic [3:0]         state
);

   state_t    cur;
   op_class_t cls;
   logic      is_bne;
   logic      lw_q;
   logic      bne_q;
   logic      illegal_q;

   mips_opcode_decode u_dec (
      .opcode (opcode),
      .cls    (cls),
      .is_bne (is_bne)
   );

   assign state   = cur;
   assign illegal = illegal_q;

   // Instruction flavour is captured in DECODE so later states
   // do not depend on the IR staying untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur         <= S_FETCH;
         lw_q        <= 1'b0;
         bne_q       <= 1'b0;
         illegal_q   <= 1'b0;
         instr_count <= '0;
      end else begin
         if (retire)
            instr_count <= instr_count + COUNT_W'(1);
         unique case (cur)
            S_FETCH:
               if (mem_ready) cur <= S_DECODE;
            S_DECODE: begin
               lw_q  <= cls.lw;
               bne_q <= is_bne;
               unique case (1'b1)
                  cls.r:          cur <= S_R_EXEC;
                  cls.lw, cls.sw: cur <= S_MEM_ADDR;
                  cls.br:         cur <= S_BRANCH;
                  cls.j:          cur <= S_JUMP;
                  cls.addi:       cur <= S_ADDI_EXEC;
                  default: begin
                     cur       <= S_TRAP;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            S_MEM_ADDR:
               cur <= lw_q ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:
               if (mem_ready) cur <= S_MEM_WB;
            S_MEM_WB:    cur <= S_FETCH;
            S_MEM_WRITE:
               if (mem_ready) cur <= S_FETCH;
            S_R_EXEC:    cur <= S_R_WB;
            S_R_WB:      cur <= S_FETCH;
            S_BRANCH:    cur <= S_FETCH;
            S_JUMP:      cur <= S_FETCH;
            S_ADDI_EXEC: cur <= S_ADDI_WB;
            S_ADDI_WB:   cur <= S_FETCH;
            S_TRAP:      cur <= S_TRAP;
            default:     cur <= S_FETCH;
         endcase
      end
   end

   // Moore decode; reset blanks every strobe immediately.
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      pc_source  = PCS_ALU;
      retire     = 1'b0;
      if (!reset) begin
         unique case (cur)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_en     = mem_ready;
            end
            S_DECODE:
               alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               retire    = mem_ready;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_SUB;
               pc_source = PCS_ALUOUT;
               pc_en     = bne_q ? ~zero : zero;
               retire    = 1'b1;
            end
            S_JUMP: begin
               pc_source = PCS_JUMP;
               pc_en     = 1'b1;
               retire    = 1'b1;
            end
            S_ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM (COUNT_W=4 to
// exercise counter wrap).
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'b100011;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
   logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       retire, illegal;
   logic [3:0] instr_count;
   logic [3:0] state;
   logic [15:0] ctl;

   int tests = 0;
   int fails = 0;

   // {mr,mw,iod,irw,pce, rw,rd,m2r, a, b[2], op[2], ps[2], ret}
   localparam logic [15:0] C_FETCH    = 16'b10011_000_0_01_00_00_0;
   localparam logic [15:0] C_FETCH_W  = 16'b10000_000_0_01_00_00_0;
   localparam logic [15:0] C_DECODE   = 16'b00000_000_0_11_00_00_0;
   localparam logic [15:0] C_MADDR    = 16'b00000_000_1_10_00_00_0;
   localparam logic [15:0] C_MREAD    = 16'b10100_000_0_00_00_00_0;
   localparam logic [15:0] C_MWB      = 16'b00000_101_0_00_00_00_1;
   localparam logic [15:0] C_MWR_W    = 16'b01100_000_0_00_00_00_0;
   localparam logic [15:0] C_MWR      = 16'b01100_000_0_00_00_00_1;
   localparam logic [15:0] C_REXEC    = 16'b00000_000_1_00_10_00_0;
   localparam logic [15:0] C_RWB      = 16'b00000_110_0_00_00_00_1;
   localparam logic [15:0] C_BR_TAKE  = 16'b00001_000_1_00_01_01_1;
   localparam logic [15:0] C_BR_NOT   = 16'b00000_000_1_00_01_01_1;
   localparam logic [15:0] C_JUMP     = 16'b00001_000_0_00_00_10_1;
   localparam logic [15:0] C_AEXEC    = 16'b00000_000_1_10_00_00_0;
   localparam logic [15:0] C_AWB      = 16'b00000_100_0_00_00_00_1;

   assign ctl = {mem_read, mem_write, i_or_d, ir_write, pc_en,
                 reg_write, reg_dst, mem_to_reg, alu_src_a,
                 alu_src_b, alu_op, pc_source, retire};

   mips_multicycle_control #(.COUNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .i_or_d      (i_or_d),
      .ir_write    (ir_write),
      .pc_en       (pc_en),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .pc_source   (pc_source),
      .retire      (retire),
      .instr_count (instr_count),
      .illegal     (illegal),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at posedge+1; outputs are checked 1 time unit later.
   task automatic cyc(input string tag, input logic [3:0] st,
                      input logic [15:0] c);
      #1;
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".ctl"}, 32'(ctl), 32'(c));
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ctl", 32'(ctl), 32'h0);
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.count", 32'(instr_count), 32'd0);
      chk("rst.illegal", 32'(illegal), 32'd0);
      reset = 1'b0;

      // lw, zero wait: 0,1,2,3,4,0
      opcode = 6'b100011;
      cyc("lw.f", 4'd0, C_FETCH);
      cyc("lw.d", 4'd1, C_DECODE);
      cyc("lw.a", 4'd2, C_MADDR);
      cyc("lw.r", 4'd3, C_MREAD);
      cyc("lw.wb", 4'd4, C_MWB);
      chk("lw.count", 32'(instr_count), 32'd1);

      // sw with 3 wait cycles in MEM_WRITE, plus a FETCH wait first
      opcode = 6'b101011;
      mem_ready = 1'b0;
      cyc("sw.fw", 4'd0, C_FETCH_W);
      mem_ready = 1'b1;
      cyc("sw.f", 4'd0, C_FETCH);
      cyc("sw.d", 4'd1, C_DECODE);
      cyc("sw.a", 4'd2, C_MADDR);
      mem_ready = 1'b0;
      cyc("sw.w0", 4'd5, C_MWR_W);
      cyc("sw.w1", 4'd5, C_MWR_W);
      cyc("sw.w2", 4'd5, C_MWR_W);
      mem_ready = 1'b1;
      cyc("sw.w3", 4'd5, C_MWR);
      #1;
      chk("sw.back", 32'(state), 32'd0);
      chk("sw.count", 32'(instr_count), 32'd2);

      // R-type with mem_ready low outside memory states (ignored)
      opcode = 6'b000000;
      cyc("r.f", 4'd0, C_FETCH);
      mem_ready = 1'b0;
      cyc("r.d", 4'd1, C_DECODE);
      cyc("r.x", 4'd6, C_REXEC);
      cyc("r.wb", 4'd7, C_RWB);
      mem_ready = 1'b1;
      chk("r.count", 32'(instr_count), 32'd3);

      // beq taken, bne with zero=1 not taken, bne zero=0 taken
      opcode = 6'b000100;
      zero = 1'b1;
      cyc("beq.f", 4'd0, C_FETCH);
      cyc("beq.d", 4'd1, C_DECODE);
      cyc("beq.b", 4'd8, C_BR_TAKE);
      opcode = 6'b000101;
      cyc("bne1.f", 4'd0, C_FETCH);
      cyc("bne1.d", 4'd1, C_DECODE);
      cyc("bne1.b", 4'd8, C_BR_NOT);
      zero = 1'b0;
      cyc("bne0.f", 4'd0, C_FETCH);
      cyc("bne0.d", 4'd1, C_DECODE);
      cyc("bne0.b", 4'd8, C_BR_TAKE);

      // j and addi
      opcode = 6'b000010;
      cyc("j.f", 4'd0, C_FETCH);
      cyc("j.d", 4'd1, C_DECODE);
      cyc("j.j", 4'd9, C_JUMP);
      opcode = 6'b001000;
      cyc("addi.f", 4'd0, C_FETCH);
      cyc("addi.d", 4'd1, C_DECODE);
      cyc("addi.x", 4'd10, C_AEXEC);
      cyc("addi.wb", 4'd11, C_AWB);
      chk("mix.count", 32'(instr_count), 32'd8);

      // illegal opcode: trap held for 10 cycles without strobes
      opcode = 6'b111111;
      cyc("trap.f", 4'd0, C_FETCH);
      cyc("trap.d", 4'd1, C_DECODE);
      for (int i = 0; i < 10; i++) begin
         cyc("trap.hold", 4'd15, 16'h0);
         chk("trap.illegal", 32'(illegal), 32'd1);
      end
      chk("trap.count", 32'(instr_count), 32'd8);
      reset = 1'b1;
      #1;
      chk("trst.illegal", 32'(illegal), 32'd0);
      chk("trst.state", 32'(state), 32'd0);
      chk("trst.count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // addi to make count nonzero, then reset during a MEM_READ wait
      opcode = 6'b001000;
      cyc("a2.f", 4'd0, C_FETCH);
      cyc("a2.d", 4'd1, C_DECODE);
      cyc("a2.x", 4'd10, C_AEXEC);
      cyc("a2.wb", 4'd11, C_AWB);
      chk("a2.count", 32'(instr_count), 32'd1);
      opcode = 6'b100011;
      cyc("lw2.f", 4'd0, C_FETCH);
      cyc("lw2.d", 4'd1, C_DECODE);
      cyc("lw2.a", 4'd2, C_MADDR);
      mem_ready = 1'b0;
      cyc("lw2.r0", 4'd3, C_MREAD);
      #1;
      reset = 1'b1;
      #1;
      chk("mrst.ctl", 32'(ctl), 32'h0);
      chk("mrst.state", 32'(state), 32'd0);
      chk("mrst.count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
      chk("mrst.hold", 32'(ctl), 32'h0);
      reset = 1'b0;
      mem_ready = 1'b1;

      // 17 R-types wrap a 4-bit counter to 1
      opcode = 6'b000000;
      for (int i = 0; i < 17; i++) begin
         cyc("wr.f", 4'd0, C_FETCH);
         cyc("wr.d", 4'd1, C_DECODE);
         cyc("wr.x", 4'd6, C_REXEC);
         cyc("wr.wb", 4'd7, C_RWB);
         if (i == 15)
            chk("wrap.zero", 32'(instr_count), 32'd0);
      end
      chk("wrap.count", 32'(instr_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
